rtc_aou_wr_sched: RTL and testbench
===================================

Name: rtc_aou_wr_sched

Overview:
- Sequences APB-side register-write requests (CR, MR, DIV, counter clear, interrupt clear) into the RTC always-on (AOU) domain, one at a time.
- Uses a 4-phase req/ack handshake whose ack returns already synchronised to pclk.
- Sits between the RTC APB interface (request pulses, shadow data held there) and the AOU write-enable inputs.
- Provides fixed-priority arbitration, per-source pending tracking, a handshake timeout and a sticky error flag.

Parameters:
- TOUT_W, 8, width of the handshake timeout counter.
- TOUT_MAX, 200, pclk cycles allowed per handshake phase before timeout (must be < 2^TOUT_W).

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- presetn  in  1  asynchronous active-low reset.
- req_pls  in  5  one-cycle write-request pulses: [0]=CR, [1]=MR, [2]=DIV, [3]=CLR, [4]=INT_CLR.
- aou_ack_sync  in  1  AOU write acknowledge, already 2-flop synchronised to pclk.
- err_clr  in  1  one-cycle pulse that clears tout_err.
- pdu_aou_wen  out  5  one-hot registered write enable to AOU, bit order as req_pls.
- pend  out  5  per-source pending flags (readable status).
- busy  out  1  high when state != IDLE or any pend bit is set.
- done_pls  out  1  one-cycle pulse when a handshake completes normally.
- done_id  out  3  index of the completed source, valid with done_pls.
- tout_err  out  1  sticky timeout flag.

Behaviour:
- Reset values: pdu_aou_wen=0, pend=0, busy=0, done_pls=0, done_id=0, tout_err=0, state=IDLE, counter=0, grant index=0.
- pend[i] is set on req_pls[i]. It is cleared on the cycle source i is granted (IDLE->REQ). If a set and a clear hit the same bit in the same cycle, the set wins.
- A new pulse for the source currently in service re-sets pend, so the source is served again afterwards with the latest shadow data.
- Priority, highest first: CLR(3), INT_CLR(4), CR(0), MR(1), DIV(2). Fixed, not rotating.
- FSM states: IDLE, REQ, WAIT_LOW.
- IDLE -> REQ: when pend != 0 and aou_ack_sync == 0.
  - Captures the winner index.
  - Sets pdu_aou_wen[winner]=1 on the same edge, so wen is visible 1 cycle after the pending bit is seen.
  - Clears the counter.
  - No grant is made while aou_ack_sync is high.
- REQ -> WAIT_LOW: on aou_ack_sync == 1. pdu_aou_wen goes to 0 on the same edge; counter is cleared.
- WAIT_LOW -> IDLE: on aou_ack_sync == 0. Asserts done_pls=1 and done_id=grant index for exactly one cycle.
- IDLE is held for at least 1 cycle between handshakes, so wen is never high on consecutive handshakes without a gap.
- Timeout counter increments in REQ and WAIT_LOW and saturates. Reaching TOUT_MAX-1 with the exit condition false counts as a timeout:
  - In REQ: tout_err=1, pdu_aou_wen=0, go to WAIT_LOW, clear counter, re-set pend for the granted source (retry).
  - In WAIT_LOW: tout_err=1, go to IDLE, no done_pls. The IDLE grant guard blocks new grants until ack falls.
- tout_err set has priority over err_clr in the same cycle.
- Ack behaviour:
  - aou_ack_sync high in IDLE (spurious) is ignored apart from blocking grants.
  - Ack rising and falling inside a single REQ cycle cannot happen, because the input is synchronised.
- Reset mid-handshake: all state returns to reset values immediately (asynchronous). The AOU side is reset by its own domain.
- Arithmetic: the counter is unsigned, TOUT_W bits wide, and saturates at all-ones (no wrap).

Decomposition:
- Shared package rtc_pkg:
  - source index constants RTC_SRC_CR=0, RTC_SRC_MR=1, RTC_SRC_DIV=2, RTC_SRC_CLR=3, RTC_SRC_INTCLR=4;
  - RTC_NUM_SRC=5;
  - FSM state encodings.
- One sub-module, rtc_wr_prio_enc: combinational fixed-priority encoder from pend[4:0] to {valid, index[2:0]}, unit-tested on its own.

Test Plan:
- Single request: req_pls=5'b00001 at cycle 0; ack rises 3 cycles after wen, falls 3 cycles after wen drops.
  -> wen=00001 at cycle 1; pend[0] cleared at cycle 1; done_pls with done_id=0 one cycle after ack falls; busy low afterwards.
- Priority: req_pls=5'b11111 in one cycle.
  -> grants follow order 3,4,0,1,2, each with exactly one done_pls; pend decrements bitwise; at least 1 IDLE cycle between wen pulses.
- Re-request in service: CR granted, then req_pls[0] pulsed while in REQ.
  -> CR completes (done_id=0), pend[0]=1, and a second CR handshake follows.
- REQ timeout: TOUT_MAX=200, ack held 0.
  -> wen drops after 200 cycles in REQ; tout_err=1; pend re-set; no done_pls. Ack later behaves correctly -> retry completes. err_clr -> tout_err=0.
- Stuck ack: ack held 1 after a grant.
  -> WAIT_LOW times out after 200 cycles, tout_err=1, state IDLE; pending MR is not granted until ack falls, then granted the next cycle.
- Reset mid-handshake: presetn low while wen=00100.
  -> wen, pend, busy, tout_err, done_pls are all 0 asynchronously; after release, no spurious grant with pend=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC APB-to-AOU write scheduler:
//   - write-source index constants and source count
//   - scheduler FSM state encoding
//   - one-hot helper used for write enables and pending-bit masks
// -----------------------------------------------------------------------------
package rtc_pkg;

  localparam int RTC_NUM_SRC = 5;

  localparam logic [2:0] RTC_SRC_CR     = 3'd0;
  localparam logic [2:0] RTC_SRC_MR     = 3'd1;
  localparam logic [2:0] RTC_SRC_DIV    = 3'd2;
  localparam logic [2:0] RTC_SRC_CLR    = 3'd3;
  localparam logic [2:0] RTC_SRC_INTCLR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } rtc_wr_state_e;

  // Source index to one-hot mask; indices outside the source range map to 0.
  function automatic logic [RTC_NUM_SRC-1:0] rtc_src_onehot(input logic [2:0] idx);
    case (idx)
      RTC_SRC_CR:     return 5'b00001;
      RTC_SRC_MR:     return 5'b00010;
      RTC_SRC_DIV:    return 5'b00100;
      RTC_SRC_CLR:    return 5'b01000;
      RTC_SRC_INTCLR: return 5'b10000;
      default:        return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/rtc_wr_prio_enc.sv
// -----------------------------------------------------------------------------
// rtc_wr_prio_enc
// Combinational fixed-priority encoder over the pending write sources.
// Priority, highest first: CLR(3), INT_CLR(4), CR(0), MR(1), DIV(2).
// Ports:
//   pend  [4:0] in   pending flags, bit order as the source indices
//   valid       out  any pending bit set
//   index [2:0] out  winning source index (0 when valid is low)
// -----------------------------------------------------------------------------
module rtc_wr_prio_enc
  import rtc_pkg::*;
(
  input  logic [RTC_NUM_SRC-1:0] pend,
  input  logic                   unused_tie,
  output logic                   valid,
  output logic [2:0]             index
);

  // Fixed-priority selection of the winning source.
  always_comb begin
    valid = 1'b1;
    index = 3'd0;
    if (pend[RTC_SRC_CLR]) begin
      index = RTC_SRC_CLR;
    end else if (pend[RTC_SRC_INTCLR]) begin
      index = RTC_SRC_INTCLR;
    end else if (pend[RTC_SRC_CR]) begin
      index = RTC_SRC_CR;
    end else if (pend[RTC_SRC_MR]) begin
      index = RTC_SRC_MR;
    end else if (pend[RTC_SRC_DIV]) begin
      index = RTC_SRC_DIV;
    end else begin
      valid = unused_tie & 1'b0;
      index = 3'd0;
    end
  end

endmodule

// File: rtl/rtc_aou_wr_sched.sv
// -----------------------------------------------------------------------------
// rtc_aou_wr_sched
// Serialises APB-side register-write requests into the RTC always-on domain
// using a 4-phase req/ack handshake (ack arrives already synchronised to pclk).
// Ports:
//   pclk, presetn      clock, asynchronous active-low reset
//   req_pls     [4:0]  one-cycle write-request pulses (CR, MR, DIV, CLR, INT_CLR)
//   aou_ack_sync       AOU write acknowledge, synchronised to pclk
//   err_clr            one-cycle pulse clearing tout_err
//   pdu_aou_wen [4:0]  one-hot registered write enable to the AOU domain
//   pend        [4:0]  per-source pending flags
//   busy               FSM active or any source pending
//   done_pls, done_id  one-cycle completion pulse and completed source index
//   tout_err           sticky handshake-timeout flag
// -----------------------------------------------------------------------------
module rtc_aou_wr_sched
  import rtc_pkg::*;
#(
  parameter int TOUT_W   = 8,
  parameter int TOUT_MAX = 200
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [RTC_NUM_SRC-1:0] req_pls,
  input  logic                   aou_ack_sync,
  input  logic                   err_clr,
  output logic [RTC_NUM_SRC-1:0] pdu_aou_wen,
  output logic [RTC_NUM_SRC-1:0] pend,
  output logic                   busy,
  output logic                   done_pls,
  output logic [2:0]             done_id,
  output logic                   tout_err
);

  // Last counter value of a phase; reaching it without the exit condition is a timeout.
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_MAX - 1);
  localparam logic [TOUT_W-1:0] CNT_SAT   = {TOUT_W{1'b1}};

  rtc_wr_state_e          state_r, state_nxt_s;
  logic [TOUT_W-1:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [2:0]             gnt_r, gnt_nxt_s;
  logic                   abort_r, abort_nxt_s;
  logic [RTC_NUM_SRC-1:0] pend_r, pend_nxt_s, pend_clr_s, pend_retry_s;
  logic [RTC_NUM_SRC-1:0] wen_r, wen_nxt_s;
  logic                   done_r, done_nxt_s;
  logic [2:0]             done_id_r, done_id_nxt_s;
  logic                   tout_err_r, tout_err_nxt_s, tout_set_s;
  logic                   enc_valid_s;
  logic [2:0]             enc_idx_s;

  rtc_wr_prio_enc u_prio_enc (
    .pend       (pend_r),
    .unused_tie (1'b0),
    .valid      (enc_valid_s),
    .index      (enc_idx_s)
  );

  // Next-state, handshake outputs, timeout and pending-mask decisions.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_inc_s     = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + {{(TOUT_W-1){1'b0}}, 1'b1};
    cnt_nxt_s     = cnt_r;
    gnt_nxt_s     = gnt_r;
    abort_nxt_s   = abort_r;
    wen_nxt_s     = wen_r;
    done_nxt_s    = 1'b0;
    done_id_nxt_s = done_id_r;
    tout_set_s    = 1'b0;
    pend_clr_s    = '0;
    pend_retry_s  = '0;
    case (state_r)
      ST_IDLE: begin
        // A high ack here is either spurious or left over from a stuck
        // handshake; hold off granting until it falls.
        if (enc_valid_s && !aou_ack_sync) begin
          state_nxt_s = ST_REQ;
          gnt_nxt_s   = enc_idx_s;
          wen_nxt_s   = rtc_src_onehot(enc_idx_s);
          pend_clr_s  = rtc_src_onehot(enc_idx_s);
          cnt_nxt_s   = '0;
          abort_nxt_s = 1'b0;
        end else begin
          wen_nxt_s = '0;
        end
      end
      ST_REQ: begin
        if (aou_ack_sync) begin
          state_nxt_s = ST_WAIT_LOW;
          wen_nxt_s   = '0;
          cnt_nxt_s   = '0;
        end else if (cnt_r >= TOUT_LAST) begin
          // Abandon this attempt and re-queue the source; the closing
          // WAIT_LOW phase must not report completion.
          state_nxt_s  = ST_WAIT_LOW;
          wen_nxt_s    = '0;
          cnt_nxt_s    = '0;
          tout_set_s   = 1'b1;
          abort_nxt_s  = 1'b1;
          pend_retry_s = rtc_src_onehot(gnt_r);
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_WAIT_LOW: begin
        if (!aou_ack_sync) begin
          state_nxt_s   = ST_IDLE;
          cnt_nxt_s     = '0;
          done_nxt_s    = !abort_r;
          done_id_nxt_s = abort_r ? done_id_r : gnt_r;
          abort_nxt_s   = 1'b0;
        end else if (cnt_r >= TOUT_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          tout_set_s  = 1'b1;
          abort_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        wen_nxt_s   = '0;
        cnt_nxt_s   = '0;
        abort_nxt_s = 1'b0;
      end
    endcase
    // A fresh request pulse wins over the grant clear on the same bit.
    pend_nxt_s = (pend_r & ~pend_clr_s) | req_pls | pend_retry_s;
    if (tout_set_s) begin
      tout_err_nxt_s = 1'b1;
    end else if (err_clr) begin
      tout_err_nxt_s = 1'b0;
    end else begin
      tout_err_nxt_s = tout_err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      gnt_r      <= 3'd0;
      abort_r    <= 1'b0;
      pend_r     <= '0;
      wen_r      <= '0;
      done_r     <= 1'b0;
      done_id_r  <= 3'd0;
      tout_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      gnt_r      <= gnt_nxt_s;
      abort_r    <= abort_nxt_s;
      pend_r     <= pend_nxt_s;
      wen_r      <= wen_nxt_s;
      done_r     <= done_nxt_s;
      done_id_r  <= done_id_nxt_s;
      tout_err_r <= tout_err_nxt_s;
    end
  end

  assign pdu_aou_wen = wen_r;
  assign pend        = pend_r;
  assign busy        = (state_r != ST_IDLE) || (|pend_r);
  assign done_pls    = done_r;
  assign done_id     = done_id_r;
  assign tout_err    = tout_err_r;

endmodule

// File: tb/tb_rtc_aou_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_rtc_aou_wr_sched
// Directed self-checking bench for rtc_aou_wr_sched and its priority encoder.
// -----------------------------------------------------------------------------
module tb_rtc_aou_wr_sched;
  import rtc_pkg::*;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [4:0] req_pls;
  logic       aou_ack_sync;
  logic       err_clr;
  logic [4:0] pdu_aou_wen;
  logic [4:0] pend;
  logic       busy;
  logic       done_pls;
  logic [2:0] done_id;
  logic       tout_err;

  logic [4:0] enc_in;
  logic       enc_valid;
  logic [2:0] enc_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  rtc_aou_wr_sched #(.TOUT_W(8), .TOUT_MAX(200)) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .req_pls      (req_pls),
    .aou_ack_sync (aou_ack_sync),
    .err_clr      (err_clr),
    .pdu_aou_wen  (pdu_aou_wen),
    .pend         (pend),
    .busy         (busy),
    .done_pls     (done_pls),
    .done_id      (done_id),
    .tout_err     (tout_err)
  );

  rtc_wr_prio_enc u_enc (
    .pend       (enc_in),
    .unused_tie (1'b0),
    .valid      (enc_valid),
    .index      (enc_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Wait (bounded) for a grant, then run one full handshake for source id.
  task automatic handshake(input logic [2:0] id, input logic [4:0] exp_pend);
    logic [4:0] exp_wen;
    exp_wen = 5'b00001 << id;
    for (int i = 0; i < 10 && pdu_aou_wen == 5'b00000; i++) step();
    check("hs_wen", 32'(pdu_aou_wen), 32'(exp_wen));
    check("hs_pend", 32'(pend), 32'(exp_pend));
    aou_ack_sync = 1'b1;
    step();
    check("hs_wen_drop", 32'(pdu_aou_wen), 32'd0);
    aou_ack_sync = 1'b0;
    step();
    check("hs_done", 32'(done_pls), 32'd1);
    check("hs_done_id", 32'(done_id), 32'(id));
    check("hs_gap", 32'(pdu_aou_wen), 32'd0);
  endtask

  initial begin
    logic       ev;
    logic [2:0] ei;
    presetn = 1'b0;
    req_pls = 5'b00000;
    aou_ack_sync = 1'b0;
    err_clr = 1'b0;

    // Priority encoder on its own, all 32 patterns.
    for (int v = 0; v < 32; v++) begin
      enc_in = 5'(v);
      #1;
      ev = (enc_in != 5'b00000);
      if (enc_in[3])      ei = 3'd3;
      else if (enc_in[4]) ei = 3'd4;
      else if (enc_in[0]) ei = 3'd0;
      else if (enc_in[1]) ei = 3'd1;
      else if (enc_in[2]) ei = 3'd2;
      else                ei = 3'd0;
      check("enc", 32'({enc_valid, enc_idx}), 32'({ev, ei}));
    end

    // Reset state.
    step();
    check("rst_wen", 32'(pdu_aou_wen), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_pls), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_tout", 32'(tout_err), 32'd0);
    presetn = 1'b1;
    step();

    // Single request with 3-cycle ack delays.
    req_pls = 5'b00001;
    step();
    req_pls = 5'b00000;
    check("single_pend_set", 32'(pend), 32'h01);
    check("single_wen_pre", 32'(pdu_aou_wen), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    step();
    check("single_wen", 32'(pdu_aou_wen), 32'h01);
    check("single_pend_clr", 32'(pend), 32'd0);
    step();
    step();
    aou_ack_sync = 1'b1;
    step();
    check("single_wen_drop", 32'(pdu_aou_wen), 32'd0);
    step();
    step();
    aou_ack_sync = 1'b0;
    step();
    check("single_done", 32'(done_pls), 32'd1);
    check("single_done_id", 32'(done_id), 32'd0);
    step();
    check("single_done_once", 32'(done_pls), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // All sources at once: order 3,4,0,1,2.
    req_pls = 5'b11111;
    step();
    req_pls = 5'b00000;
    check("prio_pend_all", 32'(pend), 32'h1f);
    handshake(3'd3, 5'b10111);
    handshake(3'd4, 5'b00111);
    handshake(3'd0, 5'b00110);
    handshake(3'd1, 5'b00100);
    handshake(3'd2, 5'b00000);
    step();
    check("prio_idle", 32'(busy), 32'd0);

    // Re-request of the source in service.
    req_pls = 5'b00001;
    step();
    req_pls = 5'b00000;
    step();
    check("rereq_wen", 32'(pdu_aou_wen), 32'h01);
    req_pls = 5'b00001;
    step();
    req_pls = 5'b00000;
    check("rereq_pend", 32'(pend), 32'h01);
    check("rereq_wen_held", 32'(pdu_aou_wen), 32'h01);
    aou_ack_sync = 1'b1;
    step();
    aou_ack_sync = 1'b0;
    step();
    check("rereq_done", 32'(done_pls), 32'd1);
    check("rereq_done_id", 32'(done_id), 32'd0);
    check("rereq_pend_kept", 32'(pend), 32'h01);
    handshake(3'd0, 5'b00000);
    step();
    check("rereq_idle", 32'(busy), 32'd0);

    // REQ timeout with ack held low, then retry.
    req_pls = 5'b00001;
    step();
    req_pls = 5'b00000;
    step();
    check("rto_wen", 32'(pdu_aou_wen), 32'h01);
    repeat (199) step();
    check("rto_wen_before", 32'(pdu_aou_wen), 32'h01);
    check("rto_err_before", 32'(tout_err), 32'd0);
    step();
    check("rto_wen_drop", 32'(pdu_aou_wen), 32'd0);
    check("rto_err", 32'(tout_err), 32'd1);
    check("rto_pend_retry", 32'(pend), 32'h01);
    check("rto_no_done_a", 32'(done_pls), 32'd0);
    step();
    check("rto_no_done_b", 32'(done_pls), 32'd0);
    handshake(3'd0, 5'b00000);
    check("rto_err_sticky", 32'(tout_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("rto_err_clr", 32'(tout_err), 32'd0);

    // Stuck ack: WAIT_LOW timeout, MR held back until ack falls.
    req_pls = 5'b00001;
    step();
    req_pls = 5'b00000;
    step();
    check("stk_wen", 32'(pdu_aou_wen), 32'h01);
    aou_ack_sync = 1'b1;
    step();
    req_pls = 5'b00010;
    step();
    req_pls = 5'b00000;
    repeat (198) step();
    check("stk_err_before", 32'(tout_err), 32'd0);
    step();
    check("stk_err", 32'(tout_err), 32'd1);
    check("stk_no_done", 32'(done_pls), 32'd0);
    repeat (3) step();
    check("stk_blocked_wen", 32'(pdu_aou_wen), 32'd0);
    check("stk_blocked_pend", 32'(pend), 32'h02);
    aou_ack_sync = 1'b0;
    step();
    check("stk_grant_mr", 32'(pdu_aou_wen), 32'h02);
    aou_ack_sync = 1'b1;
    step();
    aou_ack_sync = 1'b0;
    step();
    check("stk_done_id", 32'({done_pls, done_id}), 32'h9);

    // Asynchronous reset mid-handshake (tout_err is still set here).
    req_pls = 5'b00100;
    step();
    req_pls = 5'b01000;
    step();
    req_pls = 5'b00000;
    check("rmid_wen", 32'(pdu_aou_wen), 32'h04);
    #2;
    presetn = 1'b0;
    #1;
    check("rmid_wen0", 32'(pdu_aou_wen), 32'd0);
    check("rmid_pend0", 32'(pend), 32'd0);
    check("rmid_busy0", 32'(busy), 32'd0);
    check("rmid_tout0", 32'(tout_err), 32'd0);
    check("rmid_done0", 32'(done_pls), 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    repeat (3) step();
    check("rmid_no_grant", 32'(pdu_aou_wen), 32'd0);
    check("rmid_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
